autoc_ctrl: RTL and testbench
=============================

Name: autoc_ctrl

Overview:
- Sequencer for the autocorrelation datapath: DDC sample source, DELAY-deep delay line, I/Q multipliers and accumulators.
- Enables the DDC and waits for the delay line to fill with DELAY strobed samples.
- Then runs accumulation windows of a programmable length, pulsing clear/enable/dump to the accumulators and flagging when si/sq are valid.
- Sits between the settings/control interface and the autocorrelator core.

Parameters:
- DELAY, 32, delay-line depth in samples; number of strobes counted during fill.
- WIN_W, 16, width of the window-length input and the window sample counter.
- CNT_W, 16, width of the completed-window counter.
- TIMEOUT, 4096, clocks without a strobe before a watchdog abort (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  level; 1 = operate, 0 = stop.
- one_shot  in  1  1 = stop after one window; sampled with win_len at start.
- win_len  in  WIN_W  samples per accumulation window; 0 is treated as 1.
- ddc_out_strobe  in  1  valid-sample strobe from the DDC chain.
- ddc_out_enable  out  1  enables the DDC module.
- acc_clear  out  1  1-cycle clear to the accumulators.
- acc_en  out  1  accumulate-enable to the accumulators.
- dump  out  1  1-cycle pulse: accumulators hold a finished window.
- outputting  out  1  registered; si/sq valid for the current dump.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; strobe lost during DUMP.
- win_count  out  CNT_W  completed windows since start.
- timeout_err  out  1  sticky watchdog flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, all outputs 0, all counters 0, latched window length 0.
- States: IDLE, FILL, ACCUM, DUMP. All outputs are registered except acc_en, which is decoded from state and strobe.
- IDLE:
  - ddc_out_enable=0.
  - If run=1 at edge t: latch win_len (0 -> 1) and one_shot, clear fill counter, overrun and win_count, go to FILL.
  - ddc_out_enable=1 from cycle t+1.
- FILL:
  - ddc_out_enable=1. Count strobes.
  - On the DELAY-th strobe, go to ACCUM.
  - That strobe is not accumulated; it completes the delay-line fill.
- ACCUM:
  - acc_clear=1 in the first ACCUM cycle only.
  - acc_en = ddc_out_strobe & (state==ACCUM), combinational.
  - Contract with the datapath: acc_clear and acc_en both high means load, not add.
  - Window counter counts accumulated strobes. On the latched_len-th strobe, go to DUMP.
- DUMP (exactly 1 cycle):
  - dump=1, outputting=1; outputting falls the next cycle.
  - win_count increments, wrapping modulo 2^CNT_W.
  - A strobe during DUMP is discarded and sets overrun.
  - Next state: IDLE if one_shot latched or run=0; otherwise ACCUM. There is no re-fill, because delay-line contents stay valid.
- run=0 in FILL or ACCUM: go to IDLE next edge. No dump, and no outputting for the partial window. ddc_out_enable drops the same edge.
- run=0 in DUMP: the dump completes, then IDLE.
- Windows are contiguous: every strobe after fill is accumulated except those in DUMP cycles.
- Latency: the last window strobe at edge t gives dump/outputting at t+1. The first ACCUM cycle of the next window is t+2.
- Strobe and the state-entry edge in the same cycle: in FILL it is counted; in IDLE it is ignored.
- rst_n=0 mid-operation overrides everything: IDLE, outputs 0, next cycle.
- Counters saturate nowhere except win_count, which wraps.

Optional Feature:
- Macro: AUTOC_CTRL_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT+1) counts clocks since the last strobe in FILL or ACCUM, and resets on each strobe and on state entry.
  - Reaching TIMEOUT forces IDLE, sets sticky timeout_err, and produces no dump.
  - timeout_err clears on reset or on the next IDLE->FILL start.
- When undefined: no watchdog logic; timeout_err is constant 0; FILL/ACCUM wait indefinitely.

Test Plan:
- Reset, then run=1, one_shot=1, win_len=4, strobe every 3rd clk: ddc_out_enable rises 1 clk after run.
  - 32 strobes in FILL, then acc_clear with the first ACCUM cycle, 4 acc_en pulses, one dump/outputting, return to IDLE.
  - win_count=1, ddc_out_enable=0.
- Continuous, run=1, one_shot=0, win_len=8, strobe every 2nd clk for 100 windows: 100 dumps spaced exactly 8 strobes apart, single fill only, win_count=100, overrun=0.
- win_len=0, one_shot=1: treated as 1; exactly one acc_en pulse, then dump.
- Strobe every clk, win_len=2: strobe coincident with each DUMP is dropped (no acc_en) and overrun=1 stays set.
- Drop run after 5 of 8 window strobes: IDLE next edge, no dump, win_count unchanged. rst_n=0 during FILL: all outputs 0 next edge.
- With AUTOC_CTRL_TIMEOUT_EN and TIMEOUT=16: stop strobes in ACCUM; on the 16th idle clk, IDLE, timeout_err=1, no dump. A restart clears timeout_err.

Source files
------------

// File: rtl/autoc_ctrl.sv
// Autocorrelator sequencer: fills the delay line, then runs contiguous accumulation windows.
// Optional strobe watchdog enabled by defining AUTOC_CTRL_TIMEOUT_EN.
module autoc_ctrl #(
    parameter int DELAY   = 32,
    parameter int WIN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             one_shot,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ddc_out_strobe,
    output logic             ddc_out_enable,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             dump,
    output logic             outputting,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] win_count,
    output logic             timeout_err
);

    localparam int FILL_W = $clog2(DELAY + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ACCUM,
        DUMP
    } state_t;

    if (DELAY < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("autoc_ctrl: DELAY and TIMEOUT must be at least 1");
    end

    state_t             state_q;
    logic [FILL_W-1:0]  fill_cnt_q;
    logic [FILL_W-1:0]  fill_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q;
    logic [WIN_W-1:0]   win_cnt_d;
    logic [WIN_W-1:0]   len_q;
    logic [WIN_W-1:0]   len_d;
    logic               one_shot_q;
    logic [CNT_W-1:0]   win_count_q;
    logic [CNT_W-1:0]   win_count_d;
    logic               ddc_en_q;
    logic               acc_clear_q;
    logic               dump_q;
    logic               outputting_q;
    logic               busy_q;
    logic               overrun_q;
    logic               fill_done;
    logic               win_done;

`ifdef AUTOC_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0]    to_cnt_q;
    logic [TO_W-1:0]    to_cnt_d;
    logic               to_expired;
    logic               timeout_err_q;
`endif

    // Next values of the counters and the window/fill completion decode.
    always_comb begin
        fill_cnt_d  = fill_cnt_q + 1'b1;
        win_cnt_d   = win_cnt_q + 1'b1;
        win_count_d = win_count_q + 1'b1;
        len_d       = (win_len == '0) ? WIN_W'(1) : win_len;
        fill_done   = ddc_out_strobe && (fill_cnt_q == FILL_W'(DELAY - 1));
        win_done    = ddc_out_strobe && (win_cnt_d == len_q);
`ifdef AUTOC_CTRL_TIMEOUT_EN
        to_cnt_d    = to_cnt_q + 1'b1;
        to_expired  = (to_cnt_q == TO_W'(TIMEOUT - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            win_cnt_q    <= '0;
            len_q        <= '0;
            one_shot_q   <= 1'b0;
            win_count_q  <= '0;
            ddc_en_q     <= 1'b0;
            acc_clear_q  <= 1'b0;
            dump_q       <= 1'b0;
            outputting_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef AUTOC_CTRL_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            acc_clear_q  <= 1'b0;
            dump_q       <= 1'b0;
            outputting_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q     <= FILL;
                        len_q       <= len_d;
                        one_shot_q  <= one_shot;
                        fill_cnt_q  <= '0;
                        overrun_q   <= 1'b0;
                        win_count_q <= '0;
                        ddc_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef AUTOC_CTRL_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (!run) begin
                        state_q  <= IDLE;
                        ddc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (ddc_out_strobe) begin
                        fill_cnt_q <= fill_cnt_d;
                        // The fill-completing strobe is consumed by the delay line only.
                        if (fill_done) begin
                            state_q     <= ACCUM;
                            acc_clear_q <= 1'b1;
                            win_cnt_q   <= '0;
                        end
                    end
`ifdef AUTOC_CTRL_TIMEOUT_EN
                    else if (to_expired) begin
                        state_q       <= IDLE;
                        ddc_en_q      <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end
`endif
                end
                ACCUM: begin
                    if (!run) begin
                        state_q  <= IDLE;
                        ddc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (ddc_out_strobe) begin
                        win_cnt_q <= win_cnt_d;
                        if (win_done) begin
                            state_q      <= DUMP;
                            dump_q       <= 1'b1;
                            outputting_q <= 1'b1;
                            win_count_q  <= win_count_d;
                        end
                    end
`ifdef AUTOC_CTRL_TIMEOUT_EN
                    else if (to_expired) begin
                        state_q       <= IDLE;
                        ddc_en_q      <= 1'b0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end
`endif
                end
                DUMP: begin
                    if (ddc_out_strobe) begin
                        overrun_q <= 1'b1;
                    end
                    // Delay-line contents stay valid, so the next window starts without a re-fill.
                    if (one_shot_q || !run) begin
                        state_q  <= IDLE;
                        ddc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q     <= ACCUM;
                        acc_clear_q <= 1'b1;
                        win_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ddc_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
`ifdef AUTOC_CTRL_TIMEOUT_EN
            if ((state_q == FILL || state_q == ACCUM) && run && !ddc_out_strobe && !to_expired) begin
                to_cnt_q <= to_cnt_d;
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

    assign ddc_out_enable = ddc_en_q;
    assign acc_clear      = acc_clear_q;
    assign acc_en         = ddc_out_strobe && (state_q == ACCUM);
    assign dump           = dump_q;
    assign outputting     = outputting_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign win_count      = win_count_q;
`ifdef AUTOC_CTRL_TIMEOUT_EN
    assign timeout_err    = timeout_err_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_autoc_ctrl.sv
// Scoreboard bench for autoc_ctrl: strobe patterns are planned up front, expected clears/dumps
// are derived from strobe positions and checked by an independent monitor.
module tb_autoc_ctrl;

    localparam int DELAY = 32;
    localparam int WIN_W = 16;
    localparam int CNT_W = 16;
`ifdef AUTOC_CTRL_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif
    localparam int MAXR = 4096;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic             one_shot;
    logic [WIN_W-1:0] win_len;
    logic             ddc_out_strobe;
    logic             ddc_out_enable;
    logic             acc_clear;
    logic             acc_en;
    logic             dump;
    logic             outputting;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] win_count;
    logic             timeout_err;

    typedef struct {
        int obsCyc;
        int winCount;
        int len;
    } dumpExp_t;

    dumpExp_t dumpQ[$];
    int       clearQ[$];
    int       checks = 0;
    int       passes = 0;
    int       cyc = 0;
    int       accCnt = 0;
    bit       prevDump = 1'b0;
    bit       strb[MAXR];

    autoc_ctrl #(
        .DELAY  (DELAY),
        .WIN_W  (WIN_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .one_shot      (one_shot),
        .win_len       (win_len),
        .ddc_out_strobe(ddc_out_strobe),
        .ddc_out_enable(ddc_out_enable),
        .acc_clear     (acc_clear),
        .acc_en        (acc_en),
        .dump          (dump),
        .outputting    (outputting),
        .busy          (busy),
        .overrun       (overrun),
        .win_count     (win_count),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops expected clears and dumps as the DUT presents them.
    always @(negedge clk) begin
        if (acc_clear) begin
            if (clearQ.size() == 0) begin
                checkOutput("unexpected acc_clear", cyc, -1);
            end else begin
                checkOutput("acc_clear cycle", cyc, clearQ.pop_front());
            end
            accCnt = acc_en ? 1 : 0;
        end else if (acc_en) begin
            accCnt++;
        end
        if (prevDump) begin
            checkOutput("outputting falls after dump", outputting, 0);
        end
        if (dump) begin
            if (dumpQ.size() == 0) begin
                checkOutput("unexpected dump", cyc, -1);
            end else begin
                dumpExp_t e;
                e = dumpQ.pop_front();
                checkOutput("dump cycle", cyc, e.obsCyc);
                checkOutput("win_count at dump", win_count, e.winCount);
                checkOutput("acc_en pulses in window", accCnt, e.len);
                checkOutput("outputting with dump", outputting, 1);
                checkOutput("no acc_en in DUMP", acc_en, 0);
            end
        end
        prevDump = dump;
    end

    // Fill strb[] with a periodic (period>0) or random pattern; random gaps are capped at 8.
    task automatic makePattern(input int period);
        int phase;
        int gap;
        phase = (period > 0) ? $urandom_range(period - 1, 0) : 0;
        gap = 0;
        for (int i = 0; i < MAXR; i++) begin
            if (period > 0) begin
                strb[i] = ((i % period) == phase);
            end else begin
                strb[i] = ($urandom_range(1, 0) == 1) || (gap >= 8);
            end
            gap = strb[i] ? 0 : gap + 1;
        end
    endtask

    // Index of the n-th strobe at or after edge 'from', or -1 if the pattern is too short.
    function automatic int nthStrobe(input int from, input int n);
        int c;
        c = 0;
        for (int i = from; i < MAXR; i++) begin
            if (strb[i]) begin
                c++;
                if (c == n) return i;
            end
        end
        return -1;
    endfunction

    // Runs one start-to-stop session. abortAfter >= 0 drops run after that many strobes of an extra window.
    task automatic applyStimulus(input int len, input bit oneShot, input int period, input int nWin, input int abortAfter);
        int effLen;
        int base;
        int fillEnd;
        int start;
        int clearObs;
        int last;
        int stopEdge;
        bit dropped;
        effLen = (len == 0) ? 1 : len;
        makePattern(period);
        base = cyc + 1;
        fillEnd = nthStrobe(1, DELAY);
        if (fillEnd < 0) begin
            $display("[TB] FAIL pattern too short for fill");
            $fatal(1);
        end
        start = fillEnd + 1;
        clearObs = fillEnd;
        dropped = 1'b0;
        stopEdge = fillEnd + 1;
        for (int w = 0; w < nWin; w++) begin
            clearQ.push_back(base + clearObs);
            last = nthStrobe(start, effLen);
            if (last < 0) begin
                $display("[TB] FAIL pattern too short for window %0d", w);
                $fatal(1);
            end
            dumpQ.push_back('{base + last, w + 1, effLen});
            if (strb[last + 1]) dropped = 1'b1;
            clearObs = last + 1;
            start = last + 2;
            stopEdge = last + 1;
        end
        if (abortAfter >= 0) begin
            clearQ.push_back(base + clearObs);
            last = nthStrobe(start, abortAfter);
            stopEdge = last + 1;
        end
        for (int r = 0; r <= stopEdge; r++) begin
            run = (r < stopEdge);
            ddc_out_strobe = strb[r];
            win_len = WIN_W'(len);
            one_shot = oneShot;
            @(posedge clk);
            #1;
            if (r == 0) begin
                checkOutput("ddc_out_enable after start", ddc_out_enable, 1);
                checkOutput("busy after start", busy, 1);
                checkOutput("timeout_err cleared at start", timeout_err, 0);
            end
        end
        checkOutput("ddc_out_enable after stop", ddc_out_enable, 0);
        checkOutput("busy after stop", busy, 0);
        run = 1'b0;
        ddc_out_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final win_count", win_count, nWin);
        checkOutput("final overrun", overrun, dropped);
        checkOutput("dump queue drained", dumpQ.size(), 0);
        checkOutput("clear queue drained", clearQ.size(), 0);
        checkOutput("timeout_err idle", timeout_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b0;
        one_shot = 1'b0;
        win_len = '0;
        ddc_out_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ddc_out_enable", ddc_out_enable, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset dump", dump, 0);
        checkOutput("reset win_count", win_count, 0);
        checkOutput("reset overrun", overrun, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(4, 1'b1, 3, 1, -1);
        applyStimulus(8, 1'b0, 2, 100, -1);
        applyStimulus(0, 1'b1, 0, 1, -1);
        applyStimulus(2, 1'b0, 1, 5, -1);
        applyStimulus(8, 1'b0, 0, 2, 5);
        for (int k = 0; k < 3; k++) begin
            bit os;
            os = $urandom_range(1, 0) == 1;
            applyStimulus($urandom_range(6, 0), os, $urandom_range(3, 0), os ? 1 : $urandom_range(4, 1), -1);
        end

        // Reset in the middle of FILL.
        run = 1'b1;
        one_shot = 1'b0;
        win_len = WIN_W'(4);
        for (int r = 0; r < 12; r++) begin
            ddc_out_strobe = r[0];
            @(posedge clk);
            #1;
        end
        checkOutput("busy in FILL", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst in FILL ddc_out_enable", ddc_out_enable, 0);
        checkOutput("rst in FILL busy", busy, 0);
        checkOutput("rst in FILL acc_clear", acc_clear, 0);
        checkOutput("rst in FILL win_count", win_count, 0);
        rst_n = 1'b1;
        run = 1'b0;
        ddc_out_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef AUTOC_CTRL_TIMEOUT_EN
        begin
            int base;
            int fillEnd;
            int lastS;
            makePattern(2);
            fillEnd = nthStrobe(1, DELAY);
            lastS = nthStrobe(fillEnd + 1, 2);
            for (int i = lastS + 1; i < MAXR; i++) strb[i] = 1'b0;
            base = cyc + 1;
            clearQ.push_back(base + fillEnd);
            for (int r = 0; r <= lastS + TIMEOUT; r++) begin
                run = 1'b1;
                one_shot = 1'b0;
                win_len = WIN_W'(4);
                ddc_out_strobe = strb[r];
                @(posedge clk);
                #1;
                if (r == lastS + TIMEOUT - 1) begin
                    checkOutput("busy before watchdog", busy, 1);
                end
            end
            checkOutput("watchdog busy", busy, 0);
            checkOutput("watchdog timeout_err", timeout_err, 1);
            checkOutput("watchdog no dump", win_count, 0);
            run = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            checkOutput("timeout_err sticky", timeout_err, 1);
            applyStimulus(3, 1'b1, 2, 1, -1);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
